// File: rtl/sdf_pkg.sv
// sdf_pkg: shared state encoding and mux-select constants for the SDF stage controller
package sdf_pkg;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic DIN_NEW  = 1'b0;
    localparam logic DIN_DIFF = 1'b1;
    localparam logic OUT_TW   = 1'b0;
    localparam logic OUT_SUM  = 1'b1;

endpackage

// File: rtl/sdf_half_counter.sv
// sdf_half_counter: half-frame index k with half bit h, strobe-advanced, wrap pulse, sync clear
module sdf_half_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         stb,
    output logic [W-1:0] k,
    output logic         h,
    output logic         wrap
);

    assign wrap = stb && (k == '1);

    // k advances on every strobe and wraps naturally at 2^W; h flips on each wrap
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            k <= '0;
            h <= 1'b0;
        end else if (clr) begin
            k <= '0;
            h <= 1'b0;
        end else if (stb) begin
            k <= k + 1'b1;
            h <= wrap ? ~h : h;
        end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencer for one radix-2 DIF SDF FFT stage; define SDF_CTRL_FLUSH_EN to enable the frame flush
module sdf_stage_ctrl
    import sdf_pkg::*;
#(
    parameter int DLY_LOG2     = 12,
    parameter int TF_ADDR_LEN  = 12,
    parameter int TF_STEP_LOG2 = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   flush,
    input  logic                   fifo_empty,
    output logic                   fifo_wr_en,
    output logic                   fifo_rd_en,
    output logic                   fifo_din_sel,
    output logic                   out_sel,
    output logic [TF_ADDR_LEN-1:0] tf_addr,
    output logic                   tf_valid,
    output logic                   out_valid,
    output logic                   frame_start,
    output logic                   busy,
    output logic                   err_underflow,
    output logic                   err_overflow
);

    localparam int XW = DLY_LOG2 + TF_STEP_LOG2;

    state_t state, state_n;
    logic [DLY_LOG2-1:0] k;
    logic h, s, wrap, clr, run, fl, twid, bnd_flush, go_flush;
    logic wr_d, rd_d, din_d, tfv_d, fs_d, os_d;
    logic [XW-1:0] k_sh;
    logic [TF_ADDR_LEN-1:0] tfa_d;
    logic ov_q, fs_q, os_q;

    assign run  = (state == RUN);
    assign fl   = (state == FLUSH);
    assign twid = fl || (run && !h);

    // FLUSH runs on a free internal strobe; a pending flush at an idle frame boundary eats that cycle's sample
    assign s   = fl || (in_valid && !bnd_flush);
    assign clr = fl && wrap;

    sdf_half_counter #(.W(DLY_LOG2)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .stb  (s),
        .k    (k),
        .h    (h),
        .wrap (wrap)
    );

`ifdef SDF_CTRL_FLUSH_EN
    logic flush_pend;

    assign bnd_flush = run && !h && (k == '0) && flush_pend;
    assign go_flush  = bnd_flush || (run && h && wrap && (flush_pend || flush));

    // flush requests wait for the frame boundary; they are meaningless while priming
    always_ff @(posedge clk or posedge rst)
        if (rst) flush_pend <= 1'b0;
        else flush_pend <= (state == PRIME || go_flush) ? 1'b0 : (flush_pend || flush);

    // samples arriving while draining are lost, so flag it until reset
    always_ff @(posedge clk or posedge rst)
        if (rst) err_overflow <= 1'b0;
        else err_overflow <= err_overflow || (fl && in_valid);
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign bnd_flush    = 1'b0;
    assign go_flush     = 1'b0;
    assign err_overflow = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= PRIME;
        else state <= state_n;

    // next state: prime fills the FIFO once, run loops frames, flush drains one half then re-primes
    always_comb begin
        state_n = (state == PRIME && wrap) ? RUN :
                  go_flush                 ? FLUSH :
                  (fl && wrap)             ? PRIME : state;
    end

    // per-strobe control decode from the current phase, before the output register
    always_comb begin
        wr_d  = s && !fl;
        rd_d  = s && (state != PRIME);
        din_d = (s && run && h) ? DIN_DIFF : DIN_NEW;
        tfv_d = s && twid;
        k_sh  = XW'(k) << TF_STEP_LOG2;
        tfa_d = tfv_d ? TF_ADDR_LEN'(k_sh) : '0;
        fs_d  = s && run && h && (k == '0);
        os_d  = (s && run && h) ? OUT_SUM : OUT_TW;
    end

    // FIFO and twiddle controls register one cycle after their strobe; output flags wait one more for FIFO dout
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_rd_en   <= 1'b0;
            fifo_din_sel <= DIN_NEW;
            tf_valid     <= 1'b0;
            tf_addr      <= '0;
            ov_q         <= 1'b0;
            fs_q         <= 1'b0;
            os_q         <= OUT_TW;
            out_valid    <= 1'b0;
            frame_start  <= 1'b0;
            out_sel      <= OUT_TW;
        end else begin
            fifo_wr_en   <= wr_d;
            fifo_rd_en   <= rd_d;
            fifo_din_sel <= din_d;
            tf_valid     <= tfv_d;
            tf_addr      <= tfa_d;
            ov_q         <= rd_d;
            fs_q         <= fs_d;
            os_q         <= os_d;
            out_valid    <= ov_q;
            frame_start  <= fs_q;
            out_sel      <= os_q;
        end

    // busy tracks the registered state: idle only when sitting in PRIME at k==0
    always_ff @(posedge clk or posedge rst)
        if (rst) busy <= 1'b0;
        else busy <= !((state == PRIME && k == '0 && !s) || (fl && wrap));

    // reading an empty FIFO means the datapath lost sync with the controller; remember it until reset
    always_ff @(posedge clk or posedge rst)
        if (rst) err_underflow <= 1'b0;
        else err_underflow <= err_underflow || (fifo_rd_en && fifo_empty);

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: scoreboard bench for sdf_stage_ctrl with D=8; follows SDF_CTRL_FLUSH_EN if defined
module tb_sdf_stage_ctrl;

    localparam int DL = 3;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst, in_valid, flush, fifo_empty;
    logic fifo_wr_en, fifo_rd_en, fifo_din_sel, out_sel, tf_valid, out_valid;
    logic frame_start, busy, err_underflow, err_overflow;
    logic [AW-1:0] tf_addr;
    logic [21:0] outs;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;

    logic [15:0] ctl_q[$];
    logic [1:0]  out_q[$];
    logic [15:0] ce, cg;
    logic [1:0]  oe, og;

    sdf_stage_ctrl #(.DLY_LOG2(DL), .TF_ADDR_LEN(AW), .TF_STEP_LOG2(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .flush         (flush),
        .fifo_empty    (fifo_empty),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_din_sel  (fifo_din_sel),
        .out_sel       (out_sel),
        .tf_addr       (tf_addr),
        .tf_valid      (tf_valid),
        .out_valid     (out_valid),
        .frame_start   (frame_start),
        .busy          (busy),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    assign outs = {fifo_wr_en, fifo_rd_en, fifo_din_sel, out_sel, tf_valid, out_valid,
                   frame_start, busy, err_underflow, err_overflow, tf_addr};

    // expected control word: {wr, rd, din_sel, tf_valid, tf_addr}; output word: {out_sel, frame_start}
    function automatic void exp_prime();
        ctl_q.push_back({4'b1000, 12'd0});
    endfunction

    function automatic void exp_sum(input int kk);
        ctl_q.push_back({4'b1110, 12'd0});
        out_q.push_back({1'b1, kk == 0});
    endfunction

    function automatic void exp_tw(input int kk, input logic wr);
        ctl_q.push_back({wr, 3'b101, 12'(kk)});
        out_q.push_back(2'b00);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic iv, input logic fl = 1'b0, input logic fe = 1'b0);
        in_valid   = iv;
        flush      = fl;
        fifo_empty = fe;
        @(posedge clk);
        #1;
    endtask

    // monitor: pop and compare whenever the DUT presents FIFO controls or an output sample
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_wr_en || fifo_rd_en || tf_valid) begin
                checks++;
                if (ctl_q.size() == 0) begin
                    errors++;
                    $display("FAIL ctl_extra got wr=%0b rd=%0b tfv=%0b expected none", fifo_wr_en, fifo_rd_en, tf_valid);
                end else begin
                    ce = ctl_q.pop_front();
                    cg = {fifo_wr_en, fifo_rd_en, fifo_din_sel, tf_valid, ce[12] ? tf_addr : 12'd0};
                    if (cg !== ce) begin
                        errors++;
                        $display("FAIL ctl got %04h expected %04h", cg, ce);
                    end
                end
            end
            if (out_valid) begin
                checks++;
                ov_cnt++;
                if (out_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra got sel=%0b fs=%0b expected none", out_sel, frame_start);
                end else begin
                    oe = out_q.pop_front();
                    og = {out_sel, frame_start};
                    if (og !== oe) begin
                        errors++;
                        $display("FAIL out got %0b expected %0b", og, oe);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        fifo_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs), 32'd0);
        rst = 1'b0;
        cyc(0);

        exp_prime();
        cyc(1);
        chk("wr_latency", {31'd0, fifo_wr_en}, 32'd1);
        chk("busy_prime", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            exp_prime();
            cyc(1);
        end
        for (int i = 0; i < 8; i++) begin
            exp_sum(i);
            cyc(1);
        end
        for (int i = 0; i < 8; i++) begin
            exp_tw(i, 1'b1);
            cyc(1);
        end
        for (int i = 0; i < 8; i++) begin
            exp_sum(i);
            cyc(1);
        end
        repeat (4) cyc(0);
        chk("out_valid_count", 32'(ov_cnt), 32'd24);
        chk("busy_run", {31'd0, busy}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            exp_tw(i, 1'b1);
            cyc(1);
            cyc(0);
            chk("idle_no_ctl", {29'd0, fifo_wr_en, fifo_rd_en, tf_valid}, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            exp_sum(i);
            cyc(1);
            cyc(0);
            chk("idle_no_ctl", {29'd0, fifo_wr_en, fifo_rd_en, tf_valid}, 32'd0);
        end

        exp_tw(0, 1'b1);
        cyc(1);
        chk("underflow_clear", {31'd0, err_underflow}, 32'd0);
        cyc(0, 0, 1);
        chk("underflow_set", {31'd0, err_underflow}, 32'd1);
        exp_tw(1, 1'b1);
        cyc(1);
        cyc(0);
        chk("underflow_sticky", {31'd0, err_underflow}, 32'd1);
        exp_tw(2, 1'b1);
        cyc(1);
        exp_tw(3, 1'b1);
        cyc(1);
        rst = 1'b1;
        #1;
        chk("rst_mid_run", 32'(outs), 32'd0);
        ctl_q.delete();
        out_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0);

        for (int i = 0; i < 8; i++) begin
            exp_prime();
            cyc(1);
        end
        for (int i = 0; i < 3; i++) begin
            exp_sum(i);
            cyc(1);
        end
        exp_sum(3);
        cyc(1, 1);
        for (int i = 4; i < 8; i++) begin
            exp_sum(i);
            cyc(1);
        end
`ifdef SDF_CTRL_FLUSH_EN
        for (int i = 0; i < 8; i++) exp_tw(i, 1'b0);
        cyc(0);
        cyc(1);
        repeat (10) cyc(0);
        chk("busy_after_flush", {31'd0, busy}, 32'd0);
        chk("overflow_set", {31'd0, err_overflow}, 32'd1);
`else
        cyc(0);
        exp_tw(0, 1'b1);
        cyc(1);
        repeat (10) cyc(0);
        chk("busy_no_flush", {31'd0, busy}, 32'd1);
        chk("overflow_tied", {31'd0, err_overflow}, 32'd0);
`endif
        chk("ctl_q_drained", 32'(ctl_q.size()), 32'd0);
        chk("out_q_drained", 32'(out_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Sequencing controller for one radix-2 DIF single-delay-feedback (SDF) FFT stage built around a 2^DLY_LOG2-deep FIFO.
- Counts input strobes and generates the FIFO write/read enables, the FIFO-input and stage-output mux selects, and the twiddle-ROM address.
- Flushes the final frame out of the FIFO on request.
- Sits between the upstream stage's valid strobe and the FIFO/butterfly/twiddle-multiplier datapath; one instance per stage.

## Interface
Parameters:
- DLY_LOG2, 12, log2 of stage delay D (FIFO holds D samples in steady state; frame = 2D samples)
- TF_ADDR_LEN, 12, twiddle-ROM address width
- TF_STEP_LOG2, 0, left shift applied to k to form twiddle address (stage stride)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream sample strobe
- flush  in  1  pulse: drain FIFO after current frame
- fifo_empty  in  1  FIFO empty flag (checking only)
- fifo_wr_en  out  1  FIFO write enable
- fifo_rd_en  out  1  FIFO read enable
- fifo_din_sel  out  1  0 = new input sample, 1 = butterfly difference
- out_sel  out  1  0 = FIFO head × twiddle, 1 = butterfly sum
- tf_addr  out  TF_ADDR_LEN  twiddle-ROM address, (k << TF_STEP_LOG2) truncated to TF_ADDR_LEN
- tf_valid  out  1  tf_addr in use this cycle
- out_valid  out  1  stage output valid
- frame_start  out  1  marks first output sample of a frame
- busy  out  1  not in PRIME with k==0
- err_underflow  out  1  sticky: fifo_rd_en issued while fifo_empty
- err_overflow  out  1  sticky: in_valid while in FLUSH

## Operation
- Internal state:
  - k, DLY_LOG2-bit index within the half-frame;
  - h, half bit;
  - state PRIME / RUN / FLUSH;
  - flush_pend.
- Strobe s: in_valid in PRIME/RUN, an internal one-per-cycle strobe in FLUSH.
- On each s, k increments and wraps from D−1 to 0. On wrap, h toggles.
- PRIME (first D samples after reset or flush): fifo_wr_en=1, fifo_din_sel=0, no read, no output. On k wrap → RUN with h=1.
- RUN, h=1 (butterfly half): fifo_rd_en=1, fifo_wr_en=1, fifo_din_sel=1, out_sel=1, out_valid=1. frame_start=1 when k==0.
- RUN, h=0 (twiddle half): fifo_rd_en=1, fifo_wr_en=1, fifo_din_sel=0, out_sel=0, tf_valid=1, tf_addr=k<<TF_STEP_LOG2, out_valid=1.
- FIFO occupancy stays exactly D throughout RUN. The controller never consults full/empty for sequencing.
- flush sets flush_pend in any state.
  - At a frame boundary in RUN (h=0 and k==0, between strobes), a pending flush moves the state to FLUSH and clears flush_pend.
  - flush in PRIME is ignored and cleared.
- FLUSH: D internal strobes with h=0 behaviour but fifo_wr_en=0; these emit the last frame's twiddled differences. After k wraps → PRIME, k=0, h=0.
- in_valid during FLUSH: sample dropped, err_overflow set.
- err_* flags clear only on reset.

## Timing
- All outputs are registered. Controls appear 1 cycle after the strobe that causes them; the datapath delays data_in by one register to align.
- FIFO dout is valid 1 cycle after fifo_rd_en. out_valid/frame_start/out_sel are delayed to align with dout, so they appear 2 cycles after the strobe. tf_addr is issued with fifo_rd_en, giving a 1-cycle ROM read.
- Gaps in in_valid stall all counters; no output is generated without a strobe.
- Reset value of every output: 0. State after reset: PRIME, k=0, h=0, flush_pend=0.
- Reset mid-operation discards all counts immediately; the FIFO is reset by the same rst.
- flush and the boundary strobe in the same cycle: that strobe completes as RUN h=1 (k=D−1 → wrap), then FLUSH starts next cycle.

## Configuration
- SDF_CTRL_FLUSH_EN defined: FLUSH state, flush_pend and err_overflow logic are present as above.
- SDF_CTRL_FLUSH_EN undefined: flush is ignored, FLUSH is absent, err_overflow is tied 0. The last frame stays in the FIFO until the next frame's h=0 half.

## Structure
- Shared package sdf_pkg: state encoding constants (PRIME/RUN/FLUSH), mux select constants (DIN_NEW/DIN_DIFF, OUT_TW/OUT_SUM).
- One sub-module: sdf_half_counter (k/h counter with strobe, wrap pulse, sync clear).

## Test plan
Benches use DLY_LOG2=3 (D=8).
- Reset then 8 in_valid → 8 fifo_wr_en with din_sel=0, zero rd/out_valid. 9th strobe → rd+wr, din_sel=1, out_sel=1, frame_start at output.
- 32 continuous strobes → out_valid count 24. tf_addr sequence 0..7 during each h=0 half. Occupancy model is constant at 8 after priming.
- in_valid toggling 1/0 → same control sequence as the continuous case, stretched; no controls on idle cycles.
- flush at k=3 of the h=1 half → FLUSH entered after the frame boundary, 8 outputs with out_sel=0 and no writes, then busy=0. in_valid during FLUSH → err_overflow=1.
- rst asserted mid-RUN → all outputs 0 the same cycle. Next 8 strobes behave as PRIME.
- Force fifo_empty=1 during RUN → err_underflow=1 and stays set until rst.
